// File: rtl/barrier_scroller.sv
// barrier_scroller
//   Scrolls the barrier field of the LED playfield one column left on every
//   tick pulse. It spawns a new barrier at the right edge every SPACING ticks,
//   with the gap row taken from an internal 8-bit LFSR. It also detects a
//   bird/barrier collision and counts barriers passed (saturating score).
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   tick      in   1-cycle scroll strobe from the tick generator
//   pause     in   freezes scroll, spawn, LFSR and collision check while in RUN
//   start     in   level; IDLE->RUN and CRASH->IDLE
//   bird_row  in   current bird row, 0..ROWS-1
//   grid      out  barrier bitmap, bit [c*ROWS+r] = column c, row r
//   crashed   out  1 while in CRASH
//   running   out  1 while in RUN
//   score     out  barriers passed, saturates at 255
module barrier_scroller #(
  parameter int         COLS     = 16,
  parameter int         ROWS     = 16,
  parameter int         GAP      = 4,
  parameter int         SPACING  = 4,
  parameter int         BIRD_COL = 2,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    pause,
  input  logic                    start,
  input  logic [$clog2(ROWS)-1:0] bird_row,
  output logic [ROWS*COLS-1:0]    grid,
  output logic                    crashed,
  output logic                    running,
  output logic [7:0]              score
);

  localparam int            CW       = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SPACING - 1);
  localparam int            GT_MAX   = ROWS - GAP;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CRASH} state_t;

  state_t               state_q, state_d;
  logic [ROWS*COLS-1:0] grid_q, grid_d;
  logic [7:0]           score_q, score_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 crashed_q, crashed_d;
  logic                 running_q, running_d;

  logic [ROWS-1:0]      bird_col_bits;
  logic [ROWS-1:0]      spawn_col;
  logic [ROWS-1:0]      new_col;
  logic                 hit;
  logic                 lfsr_fb;
  int                   gap_top;

  // Collision looks at the registered grid; out-of-range rows never hit.
  assign bird_col_bits = grid_q[BIRD_COL*ROWS +: ROWS];
  assign hit           = (int'(bird_row) < ROWS) && bird_col_bits[bird_row];

  // Gap top folds LFSR nibble values above the last legal position back down.
  assign gap_top = (int'(lfsr_q[3:0]) > GT_MAX) ? int'(lfsr_q[3:0]) - GT_MAX
                                                : int'(lfsr_q[3:0]);

  // Solid column with a GAP-row opening starting at gap_top.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_spawn
    assign spawn_col[gi] = (gi < gap_top) || (gi >= gap_top + GAP);
  end

  assign new_col = (cnt_q == '0) ? spawn_col : '0;

  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    score_d = score_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        grid_d = '0;
        if (start) begin
          state_d = S_RUN;
          score_d = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!pause) begin
          // A collision wins over a coincident tick: the field stays put.
          if (hit) begin
            state_d = S_CRASH;
          end else if (tick) begin
            grid_d = {new_col, grid_q[ROWS*COLS-1:ROWS]};
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
            // A barrier sitting on the bird column is about to move past it.
            if ((|bird_col_bits) && (score_q != 8'hFF)) begin
              score_d = score_q + 8'd1;
            end
          end
        end
      end
      S_CRASH: begin
        if (start) begin
          state_d = S_IDLE;
          grid_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
    crashed_d = (state_d == S_CRASH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grid_q    <= '0;
      score_q   <= '0;
      lfsr_q    <= SEED;
      cnt_q     <= '0;
      crashed_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      score_q   <= score_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      crashed_q <= crashed_d;
      running_q <= running_d;
    end
  end

  assign grid    = grid_q;
  assign score   = score_q;
  assign crashed = crashed_q;
  assign running = running_q;

endmodule

// File: tb/tb_barrier_scroller.sv
// tb_barrier_scroller
//   Directed bench for barrier_scroller. Every driven cycle pushes the expected
//   post-edge outputs (from a small behavioural model) into a queue; key points
//   also push hand-computed column/score/flag values. A separate monitor pops
//   and compares one entry after every rising edge.
module tb_barrier_scroller;

  localparam int COLS     = 16;
  localparam int ROWS     = 16;
  localparam int GAP      = 4;
  localparam int SPACING  = 4;
  localparam int BIRD_COL = 2;
  localparam int TOT      = ROWS * COLS;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic             pause;
  logic             start;
  logic [3:0]       bird_row;
  logic [TOT-1:0]   grid;
  logic             crashed;
  logic             running;
  logic [7:0]       score;

  always #5 clk = ~clk;

  barrier_scroller dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .pause    (pause),
    .start    (start),
    .bird_row (bird_row),
    .grid     (grid),
    .crashed  (crashed),
    .running  (running),
    .score    (score)
  );

  typedef struct packed {
    logic [15:0]    tag;
    logic [TOT-1:0] grid;
    logic           crashed;
    logic           running;
    logic [7:0]     score;
  } exp_t;

  // kind 0: column value, 1: score, 2: {crashed, running}
  typedef struct packed {
    logic [15:0] tag;
    logic [1:0]  kind;
    logic [7:0]  col;
    logic [15:0] val;
  } hand_t;

  exp_t  exp_q[$];
  hand_t hand_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    stim_tag = 0;
  string phase    = "init";

  // ---------------- behavioural model ----------------
  logic [ROWS-1:0] m_col [COLS];
  int              m_state;   // 0 idle, 1 run, 2 crash
  logic [7:0]      m_lfsr;
  logic [7:0]      m_score;
  int              m_cnt;

  task automatic m_step(input logic r, input logic t, input logic p,
                        input logic s, input logic [3:0] b);
    logic [ROWS-1:0] barrier;
    int              v;
    int              gt;
    if (r) begin
      m_state = 0; m_lfsr = 8'hA5; m_score = 8'd0; m_cnt = 0;
      for (int c = 0; c < COLS; c++) m_col[c] = '0;
      return;
    end
    case (m_state)
      0: if (s) begin m_state = 1; m_score = 8'd0; m_cnt = 0; end
      1: if (!p) begin
        if (m_col[BIRD_COL][b]) begin
          m_state = 2;
        end else if (t) begin
          v  = int'(m_lfsr[3:0]);
          gt = (v > ROWS - GAP) ? v - (ROWS - GAP) : v;
          barrier = '1;
          for (int k = 0; k < GAP; k++) barrier[gt + k] = 1'b0;
          if (m_col[BIRD_COL] != '0 && m_score != 8'd255) m_score = m_score + 8'd1;
          for (int c = 0; c < COLS - 1; c++) m_col[c] = m_col[c + 1];
          m_col[COLS - 1] = (m_cnt == 0) ? barrier : '0;
          m_cnt  = (m_cnt + 1) % SPACING;
          m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
      end
      default: if (s) begin
        m_state = 0;
        for (int c = 0; c < COLS; c++) m_col[c] = '0;
      end
    endcase
  endtask

  function automatic logic [TOT-1:0] m_grid_flat();
    logic [TOT-1:0] g;
    g = '0;
    for (int c = 0; c < COLS; c++) g[c*ROWS +: ROWS] = m_col[c];
    return g;
  endfunction

  function automatic logic [3:0] safe_row(input logic [3:0] cur);
    if (m_col[BIRD_COL] == '0) return cur;
    for (int r = 0; r < ROWS; r++) if (!m_col[BIRD_COL][r]) return 4'(r);
    return cur;
  endfunction

  function automatic logic [3:0] solid_row();
    for (int r = 0; r < ROWS; r++) if (m_col[BIRD_COL][r]) return 4'(r);
    return 4'd0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r, input logic t, input logic p,
                       input logic s, input logic [3:0] b);
    exp_t e;
    reset = r; tick = t; pause = p; start = s; bird_row = b;
    m_step(r, t, p, s, b);
    e.tag     = 16'(stim_tag);
    e.grid    = m_grid_flat();
    e.crashed = (m_state == 2);
    e.running = (m_state == 1);
    e.score   = m_score;
    exp_q.push_back(e);
    stim_tag++;
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic cyc(input logic r, input logic t, input logic p,
                     input logic s, input logic [3:0] b);
    drive(r, t, p, s, b);
    adv();
  endtask

  task automatic hand(input logic [1:0] kind, input int col, input logic [15:0] val);
    hand_t h;
    h.tag  = 16'(stim_tag - 1);
    h.kind = kind;
    h.col  = 8'(col);
    h.val  = val;
    hand_q.push_back(h);
  endtask

  // ---------------- monitor ----------------
  exp_t        me;
  hand_t       mh;
  logic [15:0] act;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      checks += 4;
      if (grid !== me.grid) begin
        failures++;
        $display("FAIL grid [%s] tag=%0d actual=%h required=%h", phase, me.tag, grid, me.grid);
      end
      if (crashed !== me.crashed) begin
        failures++;
        $display("FAIL crashed [%s] tag=%0d actual=%b required=%b", phase, me.tag, crashed, me.crashed);
      end
      if (running !== me.running) begin
        failures++;
        $display("FAIL running [%s] tag=%0d actual=%b required=%b", phase, me.tag, running, me.running);
      end
      if (score !== me.score) begin
        failures++;
        $display("FAIL score [%s] tag=%0d actual=%0d required=%0d", phase, me.tag, score, me.score);
      end
      while (hand_q.size() > 0 && hand_q[0].tag == me.tag) begin
        mh = hand_q.pop_front();
        case (mh.kind)
          2'd0:    act = grid[int'(mh.col)*ROWS +: ROWS];
          2'd1:    act = {8'h00, score};
          default: act = {14'h0, crashed, running};
        endcase
        checks++;
        if (act !== mh.val) begin
          failures++;
          $display("FAIL hand_k%0d_c%0d [%s] tag=%0d actual=%h required=%h",
                   mh.kind, mh.col, phase, mh.tag, act, mh.val);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [3:0] b;
  int         guard;

  initial begin
    reset = 1'b1; tick = 1'b0; pause = 1'b0; start = 1'b0; bird_row = 4'd5;
    @(negedge clk);

    // Reset and idle: tick in IDLE does nothing.
    phase = "reset";
    cyc(1, 0, 0, 0, 5);
    drive(1, 1, 0, 0, 5); hand(1, 0, 16'd0); hand(2, 0, 16'b00); adv();
    cyc(0, 0, 0, 0, 5);
    drive(0, 1, 0, 0, 5); hand(0, 15, 16'h0000); adv();
    $display("[tb] reset/idle: 4 cycles issued");

    // Start, then first tick spawns a barrier with gap rows 5..8.
    phase = "spawn";
    drive(0, 0, 0, 1, 5); hand(2, 0, 16'b01); adv();
    drive(0, 1, 0, 0, 5); hand(0, 15, 16'hFE1F); hand(0, 14, 16'h0000); adv();
    $display("[tb] spawn: first barrier issued");

    // Ticks 2..13: barriers at cols 3,7,11,15.
    phase = "scroll";
    for (int i = 2; i <= 12; i++) cyc(0, 1, 0, 0, 5);
    drive(0, 1, 0, 0, 5);
    hand(0, 3, 16'hFE1F); hand(0, 7, 16'hFF0F); hand(0, 11, 16'hFFC3);
    hand(0, 15, 16'hFFC3); hand(1, 0, 16'd0); adv();
    drive(0, 1, 0, 0, 5); hand(0, 2, 16'hFE1F); hand(1, 0, 16'd0); adv();   // tick 14
    drive(0, 1, 0, 0, 5); hand(1, 0, 16'd1); adv();                         // tick 15
    cyc(0, 1, 0, 0, 5);                                                      // tick 16
    $display("[tb] scroll: 16 ticks issued");

    // Pause with ticks: nothing moves.
    phase = "pause";
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 5);
    drive(0, 0, 1, 0, 5);
    hand(0, 4, 16'hFF0F); hand(0, 8, 16'hFFC3); hand(0, 12, 16'hFFC3); hand(1, 0, 16'd1); adv();
    drive(0, 1, 0, 0, 5); hand(0, 3, 16'hFF0F); hand(0, 15, 16'h0FFF); adv(); // tick 17
    cyc(0, 1, 0, 0, 5);                                                        // tick 18
    drive(0, 1, 0, 0, 5); hand(1, 0, 16'd2); adv();                            // tick 19
    $display("[tb] pause: resume issued");

    // Crash on a non-tick cycle, then further ticks are frozen.
    phase = "crash";
    for (int i = 20; i <= 22; i++) cyc(0, 1, 0, 0, 5);
    drive(0, 0, 0, 0, 0); hand(2, 0, 16'b10); adv();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0); hand(0, 2, 16'hFFC3); hand(1, 0, 16'd2); adv();
    $display("[tb] crash: frozen field issued");

    // Back to IDLE (grid cleared, score held), then RUN clears score.
    phase = "restart";
    drive(0, 0, 0, 1, 5); hand(0, 2, 16'h0000); hand(2, 0, 16'b00); adv();
    drive(0, 0, 0, 0, 5); hand(1, 0, 16'd2); adv();
    drive(0, 0, 0, 1, 5); hand(1, 0, 16'd0); hand(2, 0, 16'b01); adv();
    $display("[tb] restart: issued");

    // Tick and hit in the same cycle: crash, no shift.
    phase = "tick_hit";
    b = 4'd5; guard = 0;
    while (m_col[BIRD_COL] == '0 && guard < 100) begin
      b = safe_row(b);
      cyc(0, 1, 0, 0, b);
      guard++;
    end
    drive(0, 1, 0, 0, solid_row()); hand(2, 0, 16'b10); adv();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    $display("[tb] tick_hit: issued after %0d ticks", guard);

    // Long run with bird in gaps until score saturates; start held early on.
    phase = "saturate";
    cyc(0, 0, 0, 1, 5);
    cyc(0, 0, 0, 1, 5);
    guard = 0;
    b = 4'd5;
    while (m_score != 8'd255 && guard < 4000) begin
      b = safe_row(b);
      cyc(0, (guard % 3) != 2, 0, guard < 100, b);
      guard++;
    end
    for (int i = 0; i < 16; i++) begin
      b = safe_row(b);
      cyc(0, 1, 0, 0, b);
    end
    drive(0, 0, 0, 0, safe_row(b)); hand(1, 0, 16'd255); hand(2, 0, 16'b01); adv();
    $display("[tb] saturate: %0d cycles issued", guard);

    // Reset mid-RUN with tick and start asserted.
    phase = "mid_reset";
    drive(1, 1, 0, 1, 5);
    hand(1, 0, 16'd0); hand(2, 0, 16'b00); hand(0, 15, 16'h0000); hand(0, 11, 16'h0000); adv();
    cyc(0, 1, 0, 0, 5);
    $display("[tb] mid_reset: issued");

    adv(); adv(); adv();
    checks++;
    if (exp_q.size() != 0 || hand_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d/%0d pending required=0/0", exp_q.size(), hand_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
